// File: rtl/cache_fill_arbiter.sv
// Miss-service controller: round-robin arbitration of NUM_REQ cache misses onto one
// pipelined memory, streaming a whole block per miss and serialising write-through stores.
module cache_fill_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_miss,
  input  logic [NUM_REQ*ADDR_W-1:0]            req_addr,
  input  logic                                 wr_req,
  input  logic [ADDR_W-1:0]                    wr_addr,
  input  logic [DATA_W-1:0]                    wr_data,
  output logic                                 wr_ack,
  output logic [NUM_REQ-1:0]                   grant,
  output logic                                 fill_valid,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0]   fill_word_idx,
  output logic [DATA_W-1:0]                    fill_data,
  output logic [NUM_REQ-1:0]                   fill_done,
  output logic                                 mem_en,
  output logic                                 mem_wr,
  output logic [ADDR_W-1:0]                    mem_addr,
  output logic [DATA_W-1:0]                    mem_wdata,
  input  logic [DATA_W-1:0]                    mem_rdata,
  input  logic                                 mem_data_valid,
  output logic                                 busy
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << (IDX_W + 1)) - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [PTR_W-1:0]  LAST_REQ = PTR_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {IDLE, WRITE, ISSUE, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [IDX_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   rcv_cnt_q, rcv_cnt_d;

  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic               in_fill;
  logic               data_window;
  logic               accept;
  logic               last_rcv;

  // First requesting index at or after ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [PTR_W-1:0]   ptr);
    logic [PTR_W:0] res;
    int             cand;
    res = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!res[PTR_W] && req[cand]) res = {1'b1, PTR_W'(cand)};
    end
    return res;
  endfunction

  always_comb begin
    {pick_found, pick_idx} = rr_pick(req_miss, rr_q);
  end

  // A return cannot precede the first issue by less than MEM_LATENCY cycles, so
  // earlier pulses in ISSUE are leftovers from a fill abandoned by reset.
  assign in_fill     = (state_q == ISSUE) || (state_q == DRAIN);
  assign data_window = (state_q == DRAIN) || (int'(issue_cnt_q) >= MEM_LATENCY);
  assign accept      = mem_data_valid && in_fill && data_window && (rcv_cnt_q < FULL_CNT);
  assign last_rcv    = accept && (rcv_cnt_q == LAST_CNT);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    base_d      = base_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    issue_cnt_d = issue_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    if (accept) rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d   = WRITE;
          wr_addr_d = wr_addr;
          wr_data_d = wr_data;
        end else if (pick_found) begin
          state_d     = ISSUE;
          gidx_d      = pick_idx;
          grant_d     = NUM_REQ'(1) << pick_idx;
          base_d      = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W] & ~OFF_MASK;
          issue_cnt_d = '0;
          rcv_cnt_d   = '0;
        end
      end
      WRITE: state_d = IDLE;
      ISSUE: begin
        issue_cnt_d = issue_cnt_q + IDX_W'(1);
        if (issue_cnt_q == LAST_IDX)
          state_d = (last_rcv || (rcv_cnt_q == FULL_CNT)) ? DONE : DRAIN;
      end
      DRAIN: if (last_rcv) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        rr_d    = (gidx_q == LAST_REQ) ? '0 : gidx_q + PTR_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      base_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      base_q      <= base_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
    end
  end

  // Memory side is decoded from registered state only.
  always_comb begin
    wr_ack    = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_done = '0;
    case (state_q)
      WRITE: begin
        wr_ack    = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = wr_addr_q;
        mem_wdata = wr_data_q;
      end
      ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = base_q + ADDR_W'({issue_cnt_q, 1'b0});
      end
      DONE:    fill_done = grant_q;
      default: ;
    endcase
  end

  assign grant         = grant_q;
  assign busy          = (state_q != IDLE);
  assign fill_valid    = accept;
  assign fill_word_idx = accept ? rcv_cnt_q[IDX_W-1:0] : '0;
  assign fill_data     = accept ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: default instance (2 req, 8 words, latency 4)
// and a swept instance (3 req, 4 words, latency 1), each with a small pipelined memory.
module tb_cache_fill_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Default instance
  logic [1:0]  a_req_miss;
  logic [31:0] a_req_addr;
  logic        wr_req;
  logic [15:0] wr_addr, wr_data;
  logic        a_wr_ack, a_fill_valid, a_mem_en, a_mem_wr, a_busy, a_mem_dv;
  logic [1:0]  a_grant, a_fill_done;
  logic [2:0]  a_fill_idx;
  logic [15:0] a_fill_data, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        stray_a = 1'b0;
  logic [3:0]  a_pv = '0;
  logic [15:0] a_pd [0:3];

  // Swept instance
  logic [2:0]  b_req_miss;
  logic [47:0] b_req_addr;
  logic        b_wr_req = 1'b0;
  logic [15:0] b_wr_addr = '0, b_wr_data = '0;
  logic        b_wr_ack, b_fill_valid, b_mem_en, b_mem_wr, b_busy;
  logic [2:0]  b_grant, b_fill_done;
  logic [1:0]  b_fill_idx;
  logic [15:0] b_fill_data, b_mem_addr, b_mem_wdata, b_pd;
  logic        b_pv = 1'b0;

  cache_fill_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8),
                       .MEM_LATENCY(4)) u_dut_a (
    .clk(clk), .rst(rst), .req_miss(a_req_miss), .req_addr(a_req_addr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(a_wr_ack),
    .grant(a_grant), .fill_valid(a_fill_valid), .fill_word_idx(a_fill_idx),
    .fill_data(a_fill_data), .fill_done(a_fill_done), .mem_en(a_mem_en),
    .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_data_valid(a_mem_dv), .busy(a_busy));

  cache_fill_arbiter #(.NUM_REQ(3), .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(4),
                       .MEM_LATENCY(1)) u_dut_b (
    .clk(clk), .rst(rst), .req_miss(b_req_miss), .req_addr(b_req_addr),
    .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ack(b_wr_ack),
    .grant(b_grant), .fill_valid(b_fill_valid), .fill_word_idx(b_fill_idx),
    .fill_data(b_fill_data), .fill_done(b_fill_done), .mem_en(b_mem_en),
    .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_pd), .mem_data_valid(b_pv), .busy(b_busy));

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Pipelined memories: read data returns exactly LATENCY cycles after the issue cycle.
  always @(posedge clk) begin
    a_pv    <= {a_pv[2:0], a_mem_en & ~a_mem_wr};
    a_pd[0] <= mdata(a_mem_addr);
    for (int i = 1; i < 4; i++) a_pd[i] <= a_pd[i-1];
    b_pv    <= b_mem_en & ~b_mem_wr;
    b_pd    <= mdata(b_mem_addr);
  end
  assign a_mem_dv    = a_pv[3] | stray_a;
  assign a_mem_rdata = a_pd[3];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_single_fill();
    logic [19:0] exp_fill;
    a_req_miss = 2'b10;
    a_req_addr = {16'h1234, 16'h0000};
    for (int c = 1; c <= 14; c++) begin
      tick();
      check_val("t1_grant", 32'(a_grant), (c <= 13) ? 32'd2 : 32'd0);
      if (c <= 8)
        check_val("t1_mem_rd", 32'({a_mem_en, a_mem_wr, a_mem_addr}),
                  32'({1'b1, 1'b0, 16'(16'h1230 + 2*(c-1))}));
      else
        check_val("t1_mem_quiet", 32'(a_mem_en), 32'd0);
      exp_fill = (c >= 5 && c <= 12) ?
                 {1'b1, 3'(c-5), mdata(16'(16'h1230 + 2*(c-5)))} : 20'd0;
      check_val("t1_fill", 32'({a_fill_valid, a_fill_idx, a_fill_data}), 32'(exp_fill));
      check_val("t1_done", 32'(a_fill_done), (c == 13) ? 32'd2 : 32'd0);
      if (c == 13) a_req_miss = 2'b00;
    end
  endtask

  task automatic run_contention_reset();
    a_req_miss = 2'b11;
    a_req_addr = {16'h2000, 16'h0100};
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (c == 1)  check_val("t2_grant_r0", 32'(a_grant), 32'd1);
      if (c == 13) check_val("t2_done_r0", 32'(a_fill_done), 32'd1);
      if (c == 14) check_val("t2_gap", 32'({a_busy, a_grant}), 32'd0);
      if (c == 15) check_val("t2_grant_r1", 32'({a_grant, a_mem_addr}), 32'({2'b10, 16'h2000}));
      if (c == 27) check_val("t2_done_r1", 32'(a_fill_done), 32'd2);
      if (c == 28) check_val("t2_gap2", 32'({a_busy, a_grant}), 32'd0);
      if (c == 29) check_val("t2_grant_r0_again", 32'({a_grant, a_mem_addr}), 32'({2'b01, 16'h0100}));
    end
    // Cycle 34 is the sixth cycle of the fill that began at cycle 29.
    rst = 1'b1;
    a_req_miss = 2'b00;
    #1;
    check_val("t4_rst_ctrl", 32'({a_busy, a_grant, a_fill_done, a_fill_valid, a_mem_en,
                                  a_mem_wr, a_wr_ack}), 32'd0);
    check_val("t4_rst_data", {a_mem_addr, a_fill_data}, 32'd0);
    for (int c = 35; c <= 37; c++) begin
      tick();
      if (c == 35) rst = 1'b0;
      check_val("t4_stale", 32'({a_busy, a_fill_valid, a_grant}), 32'd0);
    end
    a_req_miss = 2'b01;
    a_req_addr = {16'h0000, 16'h4446};
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n == 1)  check_val("t4_new_grant", 32'({a_grant, a_mem_addr}), 32'({2'b01, 16'h4440}));
      if (n == 12) check_val("t4_new_last", 32'({a_fill_valid, a_fill_idx, a_fill_data}),
                             32'({1'b1, 3'd7, mdata(16'h444E)}));
      if (n == 13) begin
        check_val("t4_new_done", 32'(a_fill_done), 32'd1);
        a_req_miss = 2'b00;
      end
      if (n == 14) check_val("t4_new_idle", 32'(a_busy), 32'd0);
    end
  endtask

  task automatic run_write_priority();
    int n;
    wr_req     = 1'b1;
    wr_addr    = 16'h8000;
    wr_data    = 16'hBEEF;
    a_req_miss = 2'b01;
    a_req_addr = {16'h0000, 16'h0010};
    tick();
    check_val("t3_wr_ctrl", 32'({a_mem_en, a_mem_wr, a_wr_ack, a_grant}), 32'b11100);
    check_val("t3_wr_bus", {a_mem_addr, a_mem_wdata}, {16'h8000, 16'hBEEF});
    wr_req = 1'b0;
    tick();
    check_val("t3_after_wr", 32'({a_wr_ack, a_busy, a_mem_en}), 32'd0);
    tick();
    check_val("t3_fill_start", 32'({a_grant, a_mem_wr, a_mem_addr}), 32'({2'b01, 1'b0, 16'h0010}));
    for (n = 4; n <= 30; n++) begin
      tick();
      if (a_fill_done != 2'b00) break;
    end
    check_val("t3_done_cycle", 32'(n), 32'd15);
    check_val("t3_done", 32'(a_fill_done), 32'd1);
    a_req_miss = 2'b00;
    tick();
  endtask

  task automatic run_stray();
    stray_a = 1'b1;
    #1;
    check_val("t6_stray", 32'({a_busy, a_fill_valid, a_fill_idx, a_fill_data}), 32'd0);
    tick();
    stray_a = 1'b0;
    check_val("t6_state", 32'({a_busy, a_mem_en, a_grant}), 32'd0);
  endtask

  task automatic run_sweep();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b_req_miss = 3'b111;
    b_req_addr = {16'h0335, 16'h020B, 16'h0105};
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 1)  check_val("t5_grant0", 32'({b_grant, b_mem_addr}), 32'({3'b001, 16'h0100}));
      if (c == 4)  check_val("t5_last_issue", 32'({b_mem_en, b_mem_addr}), 32'({1'b1, 16'h0106}));
      if (c == 5)  check_val("t5_drain", 32'({b_busy, b_mem_en, b_fill_valid, b_fill_idx, b_fill_data}),
                             32'({1'b1, 1'b0, 1'b1, 2'd3, mdata(16'h0106)}));
      if (c == 6)  check_val("t5_done0", 32'(b_fill_done), 32'd1);
      if (c == 7)  check_val("t5_gap", 32'({b_busy, b_grant}), 32'd0);
      if (c == 8)  check_val("t5_grant1", 32'({b_grant, b_mem_addr}), 32'({3'b010, 16'h0208}));
      if (c == 13) check_val("t5_done1", 32'(b_fill_done), 32'd2);
      if (c == 15) check_val("t5_grant2", 32'({b_grant, b_mem_addr}), 32'({3'b100, 16'h0330}));
      if (c == 20) check_val("t5_done2", 32'(b_fill_done), 32'd4);
      if (c == 22) check_val("t5_grant0_again", 32'(b_grant), 32'd1);
    end
    b_req_miss = 3'b000;
  endtask

  initial begin
    rst        = 1'b1;
    a_req_miss = '0;
    a_req_addr = '0;
    b_req_miss = '0;
    b_req_addr = '0;
    wr_req     = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    #2;
    check_val("rst_ctrl", 32'({a_busy, a_grant, a_fill_done, a_fill_valid, a_mem_en,
                               a_mem_wr, a_wr_ack}), 32'd0);
    check_val("rst_data", {a_mem_addr, a_mem_wdata}, 32'd0);
    check_val("rst_b", 32'({b_busy, b_grant, b_mem_en}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    run_single_fill();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_contention_reset();
    run_write_priority();
    run_stray();
    run_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
